// File: rtl/fp_add_pkg.sv
// Shared constants for the floating-point adder datapath.
// Default widths, the all-ones exponent and effective-operation encodings.
package fp_add_pkg;

  localparam int DEF_MANT_W = 24;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_LZC_W  = 5;

  localparam logic [DEF_EXP_W-1:0] EXP_MAX = {DEF_EXP_W{1'b1}};

  localparam logic EOP_ADD = 1'b0;
  localparam logic EOP_SUB = 1'b1;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over a MANT_W-bit vector.
// An all-zero input yields 0; callers detect exact zero separately.
module fp_lzc #(
  parameter int MANT_W = 24,
  parameter int LZC_W  = 5
) (
  input  logic [MANT_W-1:0] val_i,
  output logic [LZC_W-1:0]  count_o
);

  // Scanning LSB to MSB lets the highest set bit win.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (val_i[i]) count_o = LZC_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mant_alu_pipe.sv
// Two-stage mantissa add/subtract with magnitude recovery and normalisation,
// placed between operand alignment and rounding/packing.
module fp_mant_alu_pipe
  import fp_add_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int LZC_W  = DEF_LZC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              eop,
  input  logic [MANT_W-1:0] large_m,
  input  logic [MANT_W-1:0] small_m,
  input  logic [EXP_W-1:0]  large_ex,
  input  logic [EXP_W-1:0]  small_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] res_m,
  output logic [EXP_W-1:0]  res_ex,
  output logic              zero,
  output logic              sign_flip,
  output logic              overflow,
  output logic              lost_lsb
);

  localparam int CW = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // producers hold data stable while valid && !ready, and each stage advances
  // only when the stage after it is empty or being drained in the same cycle.
  logic accept, s2_load;

  logic              s1_valid_q;
  logic [MANT_W:0]   s1_sum_q, s1_sum_d;
  logic              s1_flip_q, s1_flip_d;
  logic [EXP_W-1:0]  s1_ex_q;
  logic              s1_eop_q;

  logic              out_valid_q;
  logic [MANT_W-1:0] res_m_q, res_m_d;
  logic [EXP_W-1:0]  res_ex_q, res_ex_d;
  logic              zero_q, zero_d;
  logic              sign_flip_q, sign_flip_d;
  logic              overflow_q, overflow_d;
  logic              lost_lsb_q, lost_lsb_d;

  logic [MANT_W-1:0] a_eff, b_eff;
  logic [LZC_W-1:0]  lz;
  logic [MANT_W-1:0] sum_low;
  logic [EXP_W-1:0]  ex_inc;
  logic [CW-1:0]     lz_ext, ex_ext;
  logic              carry;

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  // Stage 1: denormal hidden-bit masking and magnitude add/subtract.
  always_comb begin
    a_eff = large_m;
    b_eff = small_m;
    if (large_ex == '0) a_eff[MANT_W-1] = 1'b0;
    if (small_ex == '0) b_eff[MANT_W-1] = 1'b0;
    s1_flip_d = 1'b0;
    if (eop == EOP_SUB) begin
      if (a_eff < b_eff) begin
        s1_sum_d  = {1'b0, b_eff} - {1'b0, a_eff};
        s1_flip_d = 1'b1;
      end else begin
        s1_sum_d = {1'b0, a_eff} - {1'b0, b_eff};
      end
    end else begin
      s1_sum_d = {1'b0, a_eff} + {1'b0, b_eff};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_flip_q  <= 1'b0;
      s1_ex_q    <= '0;
      s1_eop_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_sum_q   <= s1_sum_d;
      s1_flip_q  <= s1_flip_d;
      s1_ex_q    <= large_ex;
      s1_eop_q   <= eop;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  assign sum_low = s1_sum_q[MANT_W-1:0];

  fp_lzc #(.MANT_W(MANT_W), .LZC_W(LZC_W)) u_lzc (
    .val_i   (sum_low),
    .count_o (lz)
  );

  assign ex_inc = s1_ex_q + EXP_W'(1);
  assign lz_ext = CW'(lz);
  assign ex_ext = CW'(s1_ex_q);
  assign carry  = (s1_eop_q == EOP_ADD) && s1_sum_q[MANT_W];

  // Stage 2: carry right-shift, zero detect, or left-normalise clamped so a
  // shrinking exponent bottoms out as a denormal instead of wrapping.
  always_comb begin
    res_m_d     = '0;
    res_ex_d    = '0;
    zero_d      = 1'b0;
    sign_flip_d = s1_flip_q;
    overflow_d  = 1'b0;
    lost_lsb_d  = 1'b0;
    if (carry) begin
      res_m_d    = s1_sum_q[MANT_W:1];
      lost_lsb_d = s1_sum_q[0];
      res_ex_d   = ex_inc;
      if (ex_inc == EXP_ONES) begin
        overflow_d = 1'b1;
        res_m_d    = '0;
      end
    end else if (s1_sum_q == '0) begin
      zero_d      = 1'b1;
      sign_flip_d = 1'b0;
    end else if (s1_ex_q == '0) begin
      res_m_d  = sum_low;
      res_ex_d = sum_low[MANT_W-1] ? EXP_W'(1) : '0;
    end else if (lz_ext < ex_ext) begin
      res_m_d  = sum_low << lz;
      res_ex_d = EXP_W'(ex_ext - lz_ext);
    end else begin
      res_m_d  = sum_low << (s1_ex_q - EXP_W'(1));
      res_ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_m_q     <= '0;
      res_ex_q    <= '0;
      zero_q      <= 1'b0;
      sign_flip_q <= 1'b0;
      overflow_q  <= 1'b0;
      lost_lsb_q  <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      res_m_q     <= res_m_d;
      res_ex_q    <= res_ex_d;
      zero_q      <= zero_d;
      sign_flip_q <= sign_flip_d;
      overflow_q  <= overflow_d;
      lost_lsb_q  <= lost_lsb_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign res_m     = res_m_q;
  assign res_ex    = res_ex_q;
  assign zero      = zero_q;
  assign sign_flip = sign_flip_q;
  assign overflow  = overflow_q;
  assign lost_lsb  = lost_lsb_q;

endmodule
